// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the message source, the schedule producer and the
// SHA-256 round stage: a block-input stream and a schedule-word output stream.
interface sha256_msg_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_round;
  logic        w_last;

  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, w_word, w_round, w_last
  );

  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, w_word, w_round, w_last
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 16-word block, then streams W[0..63]
// from a 16-entry circular buffer through a back-pressurable output register.
module sha256_msg_sched (
  input  logic              clk,
  input  logic              rst_n,
  sha256_msg_sched_if.slave bus
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]  r_state;
  logic [3:0]  r_ld_cnt;
  logic [6:0]  r_t;
  logic [31:0] r_buf [16];
  logic [31:0] r_w_word;
  logic [5:0]  r_w_round;
  logic        r_w_valid;
  logic        r_w_last;

  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_load;
  logic        w_sched;
  logic [3:0]  w_t4;
  logic [3:0]  w_i2;
  logic [3:0]  w_i7;
  logic [3:0]  w_i15;
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign bus.in_ready = rst_n && (r_state == LOAD);
  assign bus.w_valid  = r_w_valid;
  assign bus.w_word   = r_w_word;
  assign bus.w_round  = r_w_round;
  assign bus.w_last   = r_w_last;

  assign w_in_hs  = bus.in_valid && bus.in_ready;
  assign w_out_hs = r_w_valid && bus.w_ready;
  // r_t[6] set means all 64 words have been loaded into the output register
  assign w_load   = (r_state == EMIT) && !r_t[6] && (!r_w_valid || bus.w_ready);
  assign w_sched  = (r_t[5:4] != 2'b00);

  // Slot t&15 holds W[t-16], the oldest term, which the new word replaces
  assign w_t4  = r_t[3:0];
  assign w_i2  = w_t4 - 4'd2;
  assign w_i7  = w_t4 - 4'd7;
  assign w_i15 = w_t4 - 4'd15;

  always_comb begin
    w_next = r_buf[w_t4];
    if (w_sched) begin
      w_next = sig1(r_buf[w_i2]) + r_buf[w_i7] + sig0(r_buf[w_i15]) + r_buf[w_t4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_in_hs) begin
        r_buf[r_ld_cnt] <= bus.in_word;
      end else if (w_load && w_sched) begin
        r_buf[w_t4] <= w_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= LOAD;
      r_ld_cnt  <= '0;
      r_t       <= '0;
      r_w_word  <= '0;
      r_w_round <= '0;
      r_w_valid <= 1'b0;
      r_w_last  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_hs) begin
            r_ld_cnt <= r_ld_cnt + 4'd1;
            if (r_ld_cnt == 4'd15) begin
              r_state  <= EMIT;
              r_t      <= '0;
              r_ld_cnt <= '0;
            end
          end
        end
        EMIT: begin
          if (w_load) begin
            r_w_word  <= w_next;
            r_w_round <= r_t[5:0];
            r_w_last  <= (r_t[5:0] == 6'd63);
            r_w_valid <= 1'b1;
            r_t       <= r_t + 7'd1;
          end else if (w_out_hs) begin
            r_w_valid <= 1'b0;
            if (r_w_last) begin
              r_state <= LOAD;
              r_t     <= '0;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
